// File: rtl/pool_window_feeder_if.sv
// Pixel-stream input and 2x2 window output bundle for the pool window feeder.
// master drives pixels (upstream or testbench); slave is the feeder itself.
interface pool_window_feeder_if #(
  parameter int unsigned BITWIDTH = 17
);
  logic                       frame_start;
  logic                       pixel_valid;
  logic signed [BITWIDTH-1:0] pixel_in;
  logic signed [BITWIDTH-1:0] a;
  logic signed [BITWIDTH-1:0] b;
  logic signed [BITWIDTH-1:0] c;
  logic signed [BITWIDTH-1:0] d;
  logic                       flag_receive;
  logic                       frame_done;
  logic                       busy;

  modport master (
    output frame_start, pixel_valid, pixel_in,
    input  a, b, c, d, flag_receive, frame_done, busy
  );

  modport slave (
    input  frame_start, pixel_valid, pixel_in,
    output a, b, c, d, flag_receive, frame_done, busy
  );
endinterface

// File: rtl/pool_window_feeder.sv
// Buffers even rows of a raster feature map and emits non-overlapping 2x2 windows
// (a b / c d) one cycle after the bottom-right pixel is accepted.
module pool_window_feeder #(
  parameter int unsigned BITWIDTH = 17,
  parameter int unsigned WIDTH    = 28,
  parameter int unsigned HEIGHT   = 28
) (
  input logic               clk,
  input logic               reset,
  pool_window_feeder_if.slave bus
);
  localparam int unsigned ColW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned RowW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;

  typedef enum logic [1:0] {StFill, StPairLeft, StPairEmit} phase_e;

  logic [ColW-1:0] col_q, col_d, col_cur, left_idx;
  logic [RowW-1:0] row_q, row_d, row_cur;
  logic            last_col, last_row;
  phase_e          phase;

  logic signed [BITWIDTH-1:0] linebuf [WIDTH];
  logic signed [BITWIDTH-1:0] pending_q;
  logic signed [BITWIDTH-1:0] a_q, b_q, c_q, d_q;
  logic                       flag_q, done_q, busy_q;

  // frame_start restarts the position before the coincident pixel is placed
  always_comb begin
    col_cur  = bus.frame_start ? '0 : col_q;
    row_cur  = bus.frame_start ? '0 : row_q;
    last_col = (col_cur == ColW'(WIDTH - 1));
    last_row = (row_cur == RowW'(HEIGHT - 1));
    left_idx = col_cur & ~ColW'(1);
    if (!row_cur[0]) begin
      phase = StFill;
    end else if (!col_cur[0]) begin
      phase = StPairLeft;
    end else begin
      phase = StPairEmit;
    end
    col_d = col_cur;
    row_d = row_cur;
    if (bus.pixel_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_cur + RowW'(1);
      end else begin
        col_d = col_cur + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q  <= '0;
      row_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      flag_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      flag_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.pixel_valid) begin
        busy_q <= !(last_col && last_row);
        if (phase == StPairEmit) begin
          a_q    <= linebuf[left_idx];
          b_q    <= linebuf[col_cur];
          c_q    <= pending_q;
          d_q    <= bus.pixel_in;
          flag_q <= 1'b1;
          done_q <= last_col && last_row;
        end
      end else if (bus.frame_start) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Data storage needs no reset: every slot is written before it is read
  always_ff @(posedge clk) begin
    if (bus.pixel_valid) begin
      if (phase == StFill) begin
        linebuf[col_cur] <= bus.pixel_in;
      end
      if (phase == StPairLeft) begin
        pending_q <= bus.pixel_in;
      end
    end
  end

  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.c            = c_q;
  assign bus.d            = d_q;
  assign bus.flag_receive = flag_q;
  assign bus.frame_done   = done_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench: 4x4 frames through a scoreboard, plus a 2x2 signed case.
module tb_pool_window_feeder;
  localparam int unsigned BW = 17;
  typedef logic signed [BW-1:0] pix_t;
  typedef struct {
    int pix; bit fs; bit win; int ea; int eb; int ec; int ed; bit done;
  } vec_t;
  typedef struct {
    pix_t a; pix_t b; pix_t c; pix_t d; bit done; int due;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pool_window_feeder_if #(.BITWIDTH(BW)) bus4 ();
  pool_window_feeder_if #(.BITWIDTH(BW)) bus2 ();

  pool_window_feeder #(.BITWIDTH(BW), .WIDTH(4), .HEIGHT(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );
  pool_window_feeder #(.BITWIDTH(BW), .WIDTH(2), .HEIGHT(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t q[$];
  vec_t tbl[16];
  int checks = 0;
  int failures = 0;
  int win_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Scoreboard: a window is due exactly one cycle after its d pixel is accepted
  always @(negedge clk) begin
    bit   expw;
    exp_t e;
    expw = (q.size() > 0) && (q[0].due == cyc);
    if (bus4.flag_receive === 1'b1) begin
      win_cnt++;
      if (bus4.frame_done === 1'b1) done_cnt++;
    end
    if (expw || bus4.flag_receive !== 1'b0) begin
      checks++;
      if (!expw) begin
        failures++;
        $display("FAIL unexpected_window: got (%0d,%0d,%0d,%0d) required no strobe",
                 bus4.a, bus4.b, bus4.c, bus4.d);
      end else begin
        e = q.pop_front();
        if (bus4.flag_receive !== 1'b1 || bus4.a !== e.a || bus4.b !== e.b ||
            bus4.c !== e.c || bus4.d !== e.d || bus4.frame_done !== e.done) begin
          failures++;
          $display("FAIL window: got flag=%0b (%0d,%0d,%0d,%0d) done=%0b required (%0d,%0d,%0d,%0d) done=%0b",
                   bus4.flag_receive, bus4.a, bus4.b, bus4.c, bus4.d, bus4.frame_done,
                   e.a, e.b, e.c, e.d, e.done);
        end
      end
    end else if (bus4.frame_done !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL stray_frame_done: got %b required 0", bus4.frame_done);
    end
  end

  task automatic set_win(input int idx, input int wa, input int wb, input int wc,
                         input int wd, input bit dn);
    tbl[idx].win  = 1'b1;
    tbl[idx].ea   = wa;
    tbl[idx].eb   = wb;
    tbl[idx].ec   = wc;
    tbl[idx].ed   = wd;
    tbl[idx].done = dn;
  endtask

  // 4x4 frame with pixel values base+0..base+15 and its four expected windows
  task automatic fill_frame(input int base);
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{pix: base + i, fs: 1'b0, win: 1'b0, ea: 0, eb: 0, ec: 0, ed: 0, done: 1'b0};
    end
    set_win(5,  base + 0,  base + 1,  base + 4,  base + 5,  1'b0);
    set_win(7,  base + 2,  base + 3,  base + 6,  base + 7,  1'b0);
    set_win(13, base + 8,  base + 9,  base + 12, base + 13, 1'b0);
    set_win(15, base + 10, base + 11, base + 14, base + 15, 1'b1);
  endtask

  task automatic drive(input int pix, input bit valid, input bit fs);
    bus4.pixel_in    = pix_t'(pix);
    bus4.pixel_valid = valid;
    bus4.frame_start = fs;
    @(posedge clk);
    #1;
    bus4.pixel_valid = 1'b0;
    bus4.frame_start = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int gap);
    if (v.win) begin
      q.push_back('{a: pix_t'(v.ea), b: pix_t'(v.eb), c: pix_t'(v.ec), d: pix_t'(v.ed),
                    done: v.done, due: cyc + 1});
    end
    drive(v.pix, 1'b1, v.fs);
    repeat (gap) drive(0, 1'b0, 1'b0);
  endtask

  task automatic run_tbl(input int first, input int last, input int mode);
    int gap;
    for (int i = first; i <= last; i++) begin
      if (mode == 0) gap = 0;
      else if (i < 8) gap = 1;
      else gap = ($urandom_range(0, 2) == 0) ? 3 : 0;
      apply_vec(tbl[i], gap);
    end
  endtask

  task automatic idle_and_count(input string name, input int wins, input int dones);
    repeat (3) drive(0, 1'b0, 1'b0);
    check({name, "_windows"}, win_cnt, wins);
    check({name, "_frame_done"}, done_cnt, dones);
    check({name, "_busy_idle"}, bus4.busy, 0);
    win_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic drive2(input int pix);
    bus2.pixel_in    = pix_t'(pix);
    bus2.pixel_valid = 1'b1;
    @(posedge clk);
    #1;
    bus2.pixel_valid = 1'b0;
  endtask

  initial begin
    bus4.frame_start = 1'b0;
    bus4.pixel_valid = 1'b0;
    bus4.pixel_in    = '0;
    bus2.frame_start = 1'b0;
    bus2.pixel_valid = 1'b0;
    bus2.pixel_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", bus4.a, 0);
    check("rst_d", bus4.d, 0);
    check("rst_flag", bus4.flag_receive, 0);
    check("rst_done", bus4.frame_done, 0);
    check("rst_busy", bus4.busy, 0);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0);

    // Basic frame
    fill_frame(0);
    run_tbl(0, 0, 0);
    check("busy_rise", bus4.busy, 1);
    run_tbl(1, 15, 0);
    check("busy_fall_with_done", bus4.busy, 0);
    check("done_with_last", bus4.frame_done, 1);
    idle_and_count("basic", 4, 1);

    // Bubbles
    fill_frame(0);
    run_tbl(0, 15, 1);
    idle_and_count("bubbles", 4, 1);

    // Reset mid-frame
    fill_frame(0);
    run_tbl(0, 6, 0);
    check("busy_mid", bus4.busy, 1);
    drive(0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_a", bus4.a, 0);
      check("rstmid_b", bus4.b, 0);
      check("rstmid_c", bus4.c, 0);
      check("rstmid_d", bus4.d, 0);
      check("rstmid_busy", bus4.busy, 0);
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    win_cnt  = 0;
    done_cnt = 0;
    fill_frame(100);
    run_tbl(0, 15, 0);
    idle_and_count("after_reset", 4, 1);

    // frame_start with coincident pixel
    fill_frame(0);
    run_tbl(0, 9, 0);
    drive(0, 1'b0, 1'b0);
    win_cnt  = 0;
    done_cnt = 0;
    fill_frame(200);
    tbl[0].fs = 1'b1;
    run_tbl(0, 15, 0);
    idle_and_count("frame_start", 4, 1);

    // Back-to-back frames
    fill_frame(300);
    run_tbl(0, 15, 0);
    fill_frame(400);
    run_tbl(0, 15, 0);
    idle_and_count("back_to_back", 8, 2);

    // Signed extremes on a 2x2 map
    drive2(-65536);
    drive2(65535);
    drive2(-1);
    drive2(0);
    check("signed_flag", bus2.flag_receive, 1);
    check("signed_a", bus2.a, -65536);
    check("signed_b", bus2.b, 65535);
    check("signed_c", bus2.c, -1);
    check("signed_d", bus2.d, 0);
    check("signed_done", bus2.frame_done, 1);
    check("signed_busy", bus2.busy, 0);
    @(posedge clk);
    #1;
    check("signed_flag_pulse", bus2.flag_receive, 0);
    check("signed_hold_a", bus2.a, -65536);

    check("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
